// File: rtl/hack_bus_pkg.sv
// Shared types and constants for the Hack memory-bus arbiter.
package hack_bus_pkg;

  localparam int unsigned HACK_ADDR_W = 16;
  localparam int unsigned HACK_DATA_W = 16;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the tail lines up with the memory read data.
module rd_tag_pipe
  import hack_bus_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk_i,
  input  logic    clear_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter with bounded bus lock in front of the single Memory port.
module mem_bus_arbiter
  import hack_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = HACK_ADDR_W,
  parameter int unsigned DATA_W   = HACK_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_Req0,
  input  logic              i_Req1,
  input  logic              i_WE0,
  input  logic              i_WE1,
  input  logic [ADDR_W-1:0] i_Addr0,
  input  logic [ADDR_W-1:0] i_Addr1,
  input  logic [DATA_W-1:0] i_WData0,
  input  logic [DATA_W-1:0] i_WData1,
  input  logic              i_Lock0,
  input  logic              i_Lock1,
  output logic              o_Ack0,
  output logic              o_Ack1,
  output logic              o_RValid0,
  output logic              o_RValid1,
  output logic [DATA_W-1:0] o_RData,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  output logic              o_Mem_WE,
  input  logic [DATA_W-1:0] i_Mem_RData,
  output logic              o_Lock_Revoked
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0] req_v, lock_v;
  logic       gnt, gnt_id, owner, revoke;
  logic       sel_we;
  rd_tag_t    tag_in, tag_tail;

  assign req_v  = {i_Req1, i_Req0};
  assign lock_v = {i_Lock1, i_Lock0};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt     = 1'b0;
    gnt_id  = M_CPU;
    owner   = M_CPU;
    revoke  = 1'b0;
    if (!i_RESET) begin
      unique case (state_q)
        ARB: begin
          hold_d = '0;
          if (i_Req0 && i_Req1) begin
            gnt    = 1'b1;
            gnt_id = ptr_q;
            ptr_d  = ~ptr_q;
          end else if (i_Req0) begin
            gnt    = 1'b1;
            gnt_id = M_CPU;
          end else if (i_Req1) begin
            gnt    = 1'b1;
            gnt_id = M_DMA;
          end
          if (gnt && lock_v[gnt_id]) begin
            state_d = gnt_id ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          owner = (state_q == LOCK1);
          if (hold_q == HoldMax) begin
            // Revoke cycle issues nothing; the waiting master wins the next ARB cycle.
            revoke  = 1'b1;
            state_d = ARB;
            ptr_d   = ~owner;
            hold_d  = '0;
          end else begin
            if (req_v[owner]) begin
              gnt    = 1'b1;
              gnt_id = owner;
            end
            if (req_v[~owner]) begin
              hold_d = hold_q + HoldW'(1);
            end
            if (!lock_v[owner]) begin
              state_d = ARB;
              ptr_d   = ~owner;
              hold_d  = '0;
            end
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= ARB;
      ptr_q   <= M_CPU;
      hold_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      addr_q  <= o_Mem_Addr;
      wdata_q <= o_Mem_WData;
    end
  end

  assign sel_we         = gnt_id ? i_WE1 : i_WE0;
  assign o_Mem_Addr     = gnt ? (gnt_id ? i_Addr1 : i_Addr0) : addr_q;
  assign o_Mem_WData    = gnt ? (gnt_id ? i_WData1 : i_WData0) : wdata_q;
  assign o_Mem_WE       = gnt & sel_we;
  assign o_Ack0         = gnt & ~gnt_id;
  assign o_Ack1         = gnt & gnt_id;
  assign o_Lock_Revoked = revoke;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt & ~sel_we;
    tag_in.id    = gnt_id;
  end

  rd_tag_pipe #(
    .Depth(RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i  (i_CLK),
    .clear_i(i_RESET),
    .tag_i  (tag_in),
    .tag_o  (tag_tail)
  );

  // Tail gated by reset so a tag already at the tail is dropped as well.
  assign o_RValid0 = tag_tail.valid & ~tag_tail.id & ~i_RESET;
  assign o_RValid1 = tag_tail.valid & tag_tail.id & ~i_RESET;
  assign o_RData   = (tag_tail.valid && !i_RESET) ? i_Mem_RData : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: randomized and directed traffic against a rule-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wd0, wd1, rdata, mem_wdata, mem_rdata;
  logic ack0, ack1, rv0, rv1, mem_we, revoked;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .i_CLK(clk), .i_RESET(rst),
    .i_Req0(req0), .i_Req1(req1), .i_WE0(we0), .i_WE1(we1),
    .i_Addr0(addr0), .i_Addr1(addr1), .i_WData0(wd0), .i_WData1(wd1),
    .i_Lock0(lock0), .i_Lock1(lock1),
    .o_Ack0(ack0), .o_Ack1(ack1), .o_RValid0(rv0), .o_RValid1(rv1),
    .o_RData(rdata), .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata),
    .o_Mem_WE(mem_we), .i_Mem_RData(mem_rdata), .o_Lock_Revoked(revoked)
  );

  // Synchronous single-port memory stub.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } txn_t;
  typedef struct {
    int id; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic revoke; bit zero;
  } exp_t;
  typedef struct { int id; logic [DW-1:0] data; int due; } rd_t;

  txn_t txq0[$], txq1[$];
  exp_t gq[$];
  rd_t  rq[$];

  int checks = 0, failures = 0, cyc = 0, revokes_seen = 0;
  bit ack_seen0 = 0, ack_seen1 = 0, zero_mode = 0;

  // Reference model state: lock owner (-1 = none), favoured master, hold count.
  int owner = -1, fav = 0, hold = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  function automatic txn_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic apply_inputs();
    req0 = (txq0.size() > 0);
    req1 = (txq1.size() > 0);
    we0 = req0 ? txq0[0].we : 1'b0;  addr0 = req0 ? txq0[0].addr : '0;
    wd0 = req0 ? txq0[0].data : '0;
    we1 = req1 ? txq1[0].we : 1'b0;  addr1 = req1 ? txq1[0].addr : '0;
    wd1 = req1 ? txq1[0].data : '0;
  endtask

  task automatic step_model();
    exp_t e;
    txn_t t;
    rd_t r;
    int g, other;
    bit rqv[2], lkv[2];
    rqv[0] = req0; rqv[1] = req1; lkv[0] = lock0; lkv[1] = lock1;
    e.revoke = 1'b0; e.zero = zero_mode; g = -1;
    if (rst) begin
      e.id = -1; e.we = 1'b0; e.addr = last_addr; e.wdata = last_wdata;
      gq.push_back(e);
      owner = -1; fav = 0; hold = 0; last_addr = '0; last_wdata = '0;
      rq.delete();
      return;
    end
    if (owner >= 0) begin
      other = 1 - owner;
      if (hold == MAX_HOLD) begin
        e.revoke = 1'b1; fav = other; owner = -1; hold = 0;
      end else begin
        if (rqv[owner]) g = owner;
        if (rqv[other]) hold++;
        if (!lkv[owner]) begin fav = other; owner = -1; hold = 0; end
      end
    end else begin
      if (req0 && req1) begin g = fav; fav = 1 - fav; end
      else if (req0) g = 0;
      else if (req1) g = 1;
      if (g >= 0 && lkv[g]) begin owner = g; hold = 0; end
    end
    if (g >= 0) begin
      t = (g == 0) ? txq0[0] : txq1[0];
      e.we = t.we; e.addr = t.addr; e.wdata = t.data;
      last_addr = t.addr; last_wdata = t.data;
      if (t.we) ref_mem[t.addr] = t.data;
      else begin r.id = g; r.data = ref_mem[t.addr]; r.due = cyc + RD_LAT; rq.push_back(r); end
    end else begin
      e.we = 1'b0; e.addr = last_addr; e.wdata = last_wdata;
    end
    e.id = g;
    gq.push_back(e);
  endtask

  task automatic tick();
    apply_inputs();
    step_model();
    @(posedge clk);
    cyc++;
    #1;
    if (req0 && ack_seen0) void'(txq0.pop_front());
    if (req1 && ack_seen1) void'(txq1.pop_front());
  endtask

  task automatic do_reset();
    txq0.delete(); txq1.delete();
    lock0 = 1'b0; lock1 = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((txq0.size() > 0 || txq1.size() > 0) && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL drain_%s: requests still pending after %0d cycles, required none", name, n);
    end
    repeat (RD_LAT + 1) tick();
  endtask

  // Monitor: compares issue and read-return outputs against the model's queues.
  always @(negedge clk) begin
    exp_t e;
    rd_t r;
    logic [1:0] ea, erv;
    logic [DW-1:0] edata;
    ack_seen0 = ack0; ack_seen1 = ack1;
    if (revoked) revokes_seen++;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      ea = (e.id == 0) ? 2'b01 : (e.id == 1) ? 2'b10 : 2'b00;
      checks++;
      if ({ack1, ack0} !== ea || mem_we !== e.we || mem_addr !== e.addr ||
          mem_wdata !== e.wdata || revoked !== e.revoke) begin
        failures++;
        $display("FAIL issue c%0d: ack=%b we=%b addr=%h wd=%h rev=%b req ack=%b we=%b addr=%h wd=%h rev=%b",
                 cyc, {ack1, ack0}, mem_we, mem_addr, mem_wdata, revoked,
                 ea, e.we, e.addr, e.wdata, e.revoke);
      end
      erv = 2'b00; edata = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        erv = (r.id == 1) ? 2'b10 : 2'b01;
        edata = r.data;
      end
      checks++;
      if ({rv1, rv0} !== erv || ((erv != 2'b00 || e.zero) && rdata !== edata)) begin
        failures++;
        $display("FAIL rdata c%0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                 cyc, {rv1, rv0}, rdata, erv, edata);
      end
    end
  end

  // A request dropped before its acknowledge is a protocol violation.
  logic pend0 = 1'b0, pend1 = 1'b0;
  always @(posedge clk) begin
    if (!rst && ((pend0 && !req0) || (pend1 && !req1))) begin
      failures++;
      $display("FAIL protocol c%0d: request dropped without acknowledge", cyc);
    end
    pend0 <= req0 && !ack0 && !rst;
    pend1 <= req1 && !ack1 && !rst;
  end

  int base;

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
    apply_inputs();
    @(posedge clk); cyc++; #1;

    // 1: idle after reset, then write and read back
    do_reset();
    zero_mode = 1; repeat (5) tick(); zero_mode = 0;
    txq0.push_back(mk(1'b1, 16'h0010, 16'h1234)); tick();
    txq0.push_back(mk(1'b0, 16'h0010, 16'h0000)); drain("t1");

    // 2: both masters contend continuously
    txq0.push_back(mk(1'b1, 16'h0001, 16'hAAAA)); drain("t2a");
    txq1.push_back(mk(1'b1, 16'h0002, 16'h5555)); drain("t2b");
    do_reset();
    repeat (4) begin
      txq0.push_back(mk(1'b0, 16'h0001, 16'h0));
      txq1.push_back(mk(1'b0, 16'h0002, 16'h0));
    end
    drain("t2");

    // 3: locked burst from master 1, then master 0 after lock release
    do_reset();
    lock1 = 1'b1;
    for (int i = 0; i < 4; i++) txq1.push_back(mk(1'b1, 16'h0100 + 16'(i), 16'h0C00 + 16'(i)));
    for (int n = 0; n < 10 && txq1.size() > 0; n++) tick();
    lock1 = 1'b0;
    txq0.push_back(mk(1'b0, 16'h0101, 16'h0)); drain("t3");

    // 4: lock held with master 1 idle, master 0 waits until revoke
    do_reset();
    base = revokes_seen;
    lock1 = 1'b1;
    txq1.push_back(mk(1'b1, 16'h0200, 16'h0BEE)); tick();
    txq0.push_back(mk(1'b0, 16'h0200, 16'h0));
    repeat (12) tick();
    lock1 = 1'b0;
    repeat (3) begin
      txq0.push_back(mk(1'b0, 16'h0200, 16'h0));
      txq1.push_back(mk(1'b0, 16'h0100, 16'h0));
    end
    drain("t4");
    checks++;
    if (revokes_seen - base != 1) begin
      failures++;
      $display("FAIL revoke_count: saw %0d pulses, required 1", revokes_seen - base);
    end

    // 5: LED write from master 1, read back by master 0 the next cycle
    do_reset();
    txq1.push_back(mk(1'b1, 16'h4000, 16'h03FF)); tick();
    txq0.push_back(mk(1'b0, 16'h4000, 16'h0)); drain("t5");
    checks++;
    if (mem[16'h4000] !== 16'h03FF) begin
      failures++;
      $display("FAIL led_value: got %h, required 03ff", mem[16'h4000]);
    end

    // 6: reset right after a locked read grant
    do_reset();
    lock0 = 1'b1;
    txq0.push_back(mk(1'b0, 16'h0010, 16'h0)); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    lock0 = 1'b0;
    txq1.push_back(mk(1'b0, 16'h0010, 16'h0)); drain("t6");

    // Random traffic with random locks and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (txq0.size() == 0 && $urandom_range(0, 2) == 0)
        txq0.push_back(mk(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 16'h4000 : 16'($urandom_range(0, 15)),
                          16'($urandom)));
      if (txq1.size() == 0 && $urandom_range(0, 2) == 0)
        txq1.push_back(mk(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 16'h4000 : 16'($urandom_range(0, 15)),
                          16'($urandom)));
      if ($urandom_range(0, 7) == 0) lock0 = ~lock0;
      if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    drain("random");

    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL read_backlog: %0d reads never returned, required 0", rq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
